// File: rtl/blk_3f65be_pkg.sv
// -----------------------------------------------------------------------------
// blk_3f65be_pkg
// Shared definitions for the debug monitor RAM engine:
//   - FSM state encoding
//   - jdo bit positions used by the JTAG decode
//   - CPU register word offsets
//   - helper that packs the status register word
// -----------------------------------------------------------------------------
package blk_3f65be_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_JRD  = 2'd1,
        ST_CRD  = 2'd2
    } state_t;

    // jdo field positions
    localparam int ADDR_LSB  = 17;
    localparam int RD_BIT    = 34;
    localparam int ACK_BIT   = 35;
    localparam int WDATA_MSB = 34;
    localparam int WDATA_LSB = 3;

    // CPU register-space word offsets
    localparam int REG_STATUS  = 0;
    localparam int REG_MONDREG = 1;

    function automatic logic [31:0] status_word(input logic ready, input logic error);
        return {30'b0, error, ready};
    endfunction

endpackage

// File: rtl/blk_3f65be_if.sv
// -----------------------------------------------------------------------------
// blk_3f65be_if
// Avalon-MM slave bus between the CPU and the monitor RAM engine.
//   avs_address     ADDR_W+1 bits; MSB selects register space, else RAM word
//   avs_read/write  request strobes (held by the master while stalled)
//   avs_writedata   32-bit write data
//   avs_byteenable  byte lanes, honoured for RAM writes only
//   avs_readdata    32-bit read data, valid when read && !waitrequest
//   avs_waitrequest stall back to the master
// -----------------------------------------------------------------------------
interface blk_3f65be_if #(
    parameter int ADDR_W = 8
) ();
    logic [ADDR_W:0] avs_address;
    logic            avs_read;
    logic            avs_write;
    logic [31:0]     avs_writedata;
    logic [3:0]      avs_byteenable;
    logic [31:0]     avs_readdata;
    logic            avs_waitrequest;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        input  avs_readdata, avs_waitrequest
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        output avs_readdata, avs_waitrequest
    );
endinterface

// File: rtl/blk_3f65be_ram.sv
// -----------------------------------------------------------------------------
// blk_3f65be_ram
// Single-port 2**ADDR_W x 32-bit monitor RAM, byte-enabled write, registered
// read (data for the address presented in cycle N appears in cycle N+1).
//   clk      system clock
//   i_addr   word address
//   i_we     write enable
//   i_be     byte enables for the write
//   i_wdata  write data
//   o_q      registered read data (read-before-write)
// -----------------------------------------------------------------------------
module blk_3f65be_ram #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_we,
    input  logic [3:0]        i_be,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_q
);
    logic [31:0] r_mem [2**ADDR_W];
    logic [31:0] r_q;

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
        r_q <= r_mem[i_addr];
    end

    assign o_q = r_q;
endmodule

// File: rtl/blk_3f65be.sv
// -----------------------------------------------------------------------------
// blk_3f65be
// Debug monitor RAM engine. Decodes JTAG strobes into monitor RAM reads and
// writes and arbitrates them against CPU Avalon accesses (JTAG first).
//   clk, reset               clock, synchronous active-high reset
//   jdo                      JTAG data word
//   take_action_ocimem_a     load address / optional read / ack
//   take_action_ocimem_b     write jdo[34:3] at MonAReg, then MonAReg+1
//   take_no_action_ocimem_a  read at MonAReg, then MonAReg+1
//   avs                      CPU Avalon-MM slave bus
//   MonDReg                  last JTAG read data
//   monitor_ready/error      sticky flags, CPU sets, JTAG ack clears
//   jtag_busy                JTAG request pending or in service
// -----------------------------------------------------------------------------
module blk_3f65be #(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [37:0] jdo,
    input  logic        take_action_ocimem_a,
    input  logic        take_action_ocimem_b,
    input  logic        take_no_action_ocimem_a,
    blk_3f65be_if.slave avs,
    output logic [31:0] MonDReg,
    output logic        monitor_ready,
    output logic        monitor_error,
    output logic        jtag_busy
);
    import blk_3f65be_pkg::*;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_mon_a;
    logic [31:0]       r_mon_d;
    logic              r_ready, r_error;
    logic              r_pend, r_pend_wr, r_pend_inc;
    logic [31:0]       r_pend_wdata;
    logic [31:0]       r_readdata;
    logic              r_cpu_reg;
    logic [ADDR_W-1:0] r_cpu_word;

    logic              w_busy, w_accept;
    logic              w_sa, w_sb, w_sn;
    logic [ADDR_W-1:0] w_jdo_addr;
    logic [31:0]       w_jdo_wdata;
    logic              w_new_req, w_new_inc;
    logic              w_jreq, w_jwr, w_jinc;
    logic [ADDR_W-1:0] w_jaddr;
    logic [31:0]       w_jwdata;
    logic              w_cpu_reg;
    logic [ADDR_W-1:0] w_cpu_word;
    logic              w_wait, w_jsrv_wr, w_jsrv_rd, w_cpu_wr, w_cpu_rd, w_crd;
    logic [ADDR_W-1:0] w_ram_addr;
    logic              w_ram_we;
    logic [3:0]        w_ram_be;
    logic [31:0]       w_ram_wdata, w_ram_q, w_crd_data;
    logic              w_unused;

    // jdo bits outside the address/data/control fields carry nothing here
    assign w_unused = ^{jdo[37:36], jdo[WDATA_LSB-1:0]};

    assign w_busy   = r_pend | (r_state == ST_JRD);
    assign w_accept = ~w_busy;
    assign w_sa     = take_action_ocimem_a    & w_accept;
    assign w_sb     = take_action_ocimem_b    & w_accept;
    assign w_sn     = take_no_action_ocimem_a & w_accept;

    assign w_jdo_addr  = jdo[ADDR_LSB +: ADDR_W];
    assign w_jdo_wdata = jdo[WDATA_MSB:WDATA_LSB];

    // A freshly accepted strobe is served in its own cycle when the FSM is
    // idle, so a CPU write in that same cycle is the one that gets stalled.
    assign w_new_req = w_sb | w_sn | (w_sa & jdo[RD_BIT]);
    assign w_new_inc = w_sb | w_sn;

    assign w_jreq   = r_pend | w_new_req;
    assign w_jwr    = r_pend ? r_pend_wr    : w_sb;
    assign w_jinc   = r_pend ? r_pend_inc   : w_new_inc;
    assign w_jwdata = r_pend ? r_pend_wdata : w_jdo_wdata;
    assign w_jaddr  = w_sa ? w_jdo_addr : r_mon_a;

    assign w_cpu_reg  = avs.avs_address[ADDR_W];
    assign w_cpu_word = avs.avs_address[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_wait      = 1'b1;
        w_ram_addr  = w_cpu_word;
        w_ram_we    = 1'b0;
        w_ram_be    = avs.avs_byteenable;
        w_ram_wdata = avs.avs_writedata;
        w_jsrv_wr   = 1'b0;
        w_jsrv_rd   = 1'b0;
        w_cpu_wr    = 1'b0;
        w_cpu_rd    = 1'b0;
        w_crd       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_jreq) begin
                    w_ram_addr  = w_jaddr;
                    w_ram_be    = 4'hF;
                    w_ram_wdata = w_jwdata;
                    if (w_jwr) begin
                        w_ram_we  = 1'b1;
                        w_jsrv_wr = 1'b1;
                    end else begin
                        w_jsrv_rd = 1'b1;
                        w_next    = ST_JRD;
                    end
                end else if (avs.avs_write) begin
                    w_wait   = 1'b0;
                    w_cpu_wr = 1'b1;
                    w_ram_we = ~w_cpu_reg;
                end else if (avs.avs_read) begin
                    w_cpu_rd = 1'b1;
                    w_next   = ST_CRD;
                end
            end
            ST_JRD: begin
                w_next = ST_IDLE;
            end
            ST_CRD: begin
                w_wait = 1'b0;
                w_crd  = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_crd_data = w_ram_q;
        if (r_cpu_reg) begin
            if (r_cpu_word == ADDR_W'(REG_STATUS)) begin
                w_crd_data = status_word(r_ready, r_error);
            end else if (r_cpu_word == ADDR_W'(REG_MONDREG)) begin
                w_crd_data = r_mon_d;
            end else begin
                w_crd_data = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mon_a    <= '0;
            r_mon_d    <= '0;
            r_ready    <= 1'b0;
            r_error    <= 1'b0;
            r_pend     <= 1'b0;
            r_readdata <= '0;
        end else begin
            if (w_sa) begin
                r_mon_a <= w_jdo_addr;
            end else if (w_jsrv_wr || (r_state == ST_JRD && r_pend_inc)) begin
                r_mon_a <= r_mon_a + ADDR_W'(1);
            end

            // Strobe accepted during a CPU read completion waits one cycle
            if (w_new_req && r_state == ST_CRD) begin
                r_pend <= 1'b1;
            end else if (w_jsrv_wr || w_jsrv_rd) begin
                r_pend <= 1'b0;
            end

            if (r_state == ST_JRD) begin
                r_mon_d <= w_ram_q;
            end

            // Ack clear first so a same-cycle CPU set overrides it
            if (w_sa && jdo[ACK_BIT]) begin
                r_ready <= 1'b0;
                r_error <= 1'b0;
            end
            if (w_cpu_wr && w_cpu_reg && w_cpu_word == ADDR_W'(REG_STATUS)) begin
                if (avs.avs_writedata[0]) r_ready <= 1'b1;
                if (avs.avs_writedata[1]) r_error <= 1'b1;
            end

            if (w_crd) begin
                r_readdata <= w_crd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_new_req && r_state == ST_CRD) begin
            r_pend_wr    <= w_sb;
            r_pend_inc   <= w_new_inc;
            r_pend_wdata <= w_jdo_wdata;
        end else if (w_jsrv_rd) begin
            r_pend_inc <= w_jinc;
        end
        if (w_cpu_rd) begin
            r_cpu_reg  <= w_cpu_reg;
            r_cpu_word <= w_cpu_word;
        end
    end

    blk_3f65be_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .i_addr  (w_ram_addr),
        .i_we    (w_ram_we & ~reset),
        .i_be    (w_ram_be),
        .i_wdata (w_ram_wdata),
        .o_q     (w_ram_q)
    );

    assign avs.avs_waitrequest = reset | w_wait;
    assign avs.avs_readdata    = w_crd ? w_crd_data : r_readdata;
    assign MonDReg             = r_mon_d;
    assign monitor_ready       = r_ready;
    assign monitor_error       = r_error;
    assign jtag_busy           = w_busy;
endmodule

// File: tb/tb_blk_3f65be.sv
module tb_blk_3f65be;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [37:0] jdo = '0;
    logic        take_a = 1'b0, take_b = 1'b0, take_n = 1'b0;
    logic [31:0] mon_d;
    logic        mon_ready, mon_error, busy;

    int n_tests = 0;
    int n_fail  = 0;

    blk_3f65be_if #(.ADDR_W(8)) avs ();

    blk_3f65be #(.ADDR_W(8)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_a),
        .take_action_ocimem_b    (take_b),
        .take_no_action_ocimem_a (take_n),
        .avs                     (avs),
        .MonDReg                 (mon_d),
        .monitor_ready           (mon_ready),
        .monitor_error           (mon_error),
        .jtag_busy               (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef enum int {OP_CW, OP_CR, OP_JA, OP_JB, OP_JN, OP_MD, OP_ST} op_t;
    typedef struct {
        op_t         op;
        logic [8:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out, got no response, expected completion", name);
    endtask

    function automatic logic [37:0] jdo_a(input logic [7:0] a, input bit ack, input bit rd);
        logic [37:0] j;
        j = '0;
        j[24:17] = a;
        j[34] = rd;
        j[35] = ack;
        return j;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[34:3] = d;
        return j;
    endfunction

    task automatic cpu_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] be,
                             output int waits);
        bit done;
        done = 0;
        waits = 0;
        @(posedge clk); #1;
        avs.avs_address = a; avs.avs_writedata = d; avs.avs_byteenable = be;
        avs.avs_write = 1'b1;
        for (int n = 0; n < 10 && !done; n++) begin
            @(negedge clk);
            if (!avs.avs_waitrequest) done = 1;
            else waits++;
            @(posedge clk); #1;
        end
        avs.avs_write = 1'b0;
        if (!done) timeout("cpu_write");
    endtask

    task automatic cpu_read(input logic [8:0] a, output logic [31:0] d, output int waits);
        bit done;
        done = 0;
        waits = 0;
        d = '0;
        @(posedge clk); #1;
        avs.avs_address = a;
        avs.avs_read = 1'b1;
        for (int n = 0; n < 10 && !done; n++) begin
            @(negedge clk);
            if (!avs.avs_waitrequest) begin
                d = avs.avs_readdata;
                done = 1;
            end else begin
                waits++;
            end
            @(posedge clk); #1;
        end
        avs.avs_read = 1'b0;
        if (!done) timeout("cpu_read");
    endtask

    task automatic jtag(input int kind, input logic [37:0] j);
        bit idle;
        idle = 0;
        @(posedge clk); #1;
        jdo = j;
        take_a = (kind == 0);
        take_b = (kind == 1);
        take_n = (kind == 2);
        @(posedge clk); #1;
        take_a = 1'b0; take_b = 1'b0; take_n = 1'b0;
        repeat (4) @(posedge clk);
        for (int n = 0; n < 20 && !idle; n++) begin
            @(negedge clk);
            if (!busy) idle = 1;
        end
        if (!idle) timeout("jtag_busy");
    endtask

    initial begin
        logic [31:0] rd;
        int          w;

        avs.avs_address = '0; avs.avs_read = 1'b0; avs.avs_write = 1'b0;
        avs.avs_writedata = '0; avs.avs_byteenable = 4'hF;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_waitreq", {31'b0, avs.avs_waitrequest}, 32'd1);
        check("rst_mondreg", mon_d, 32'h0);
        check("rst_status", {30'b0, mon_error, mon_ready}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_readdata", avs.avs_readdata, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        cpu_read(9'h100, rd, w);
        check("t1_reg0", rd, 32'h0);
        check("t1_wait", w, 1);
        cpu_write(9'h005, 32'h0000_0001, 4'hF, w);
        check("t1_wr_wait", w, 0);

        // JTAG streaming writes read back by the CPU
        vq.push_back('{OP_JA, 9'h010, 32'h0,          4'hF, 32'h0,          "t2_ja"});
        vq.push_back('{OP_JB, 9'h000, 32'hDEADBEEF,   4'hF, 32'h0,          "t2_jb0"});
        vq.push_back('{OP_JB, 9'h000, 32'h12345678,   4'hF, 32'h0,          "t2_jb1"});
        vq.push_back('{OP_CR, 9'h010, 32'h0,          4'hF, 32'hDEADBEEF,   "t2_rd10"});
        vq.push_back('{OP_CR, 9'h011, 32'h0,          4'hF, 32'h12345678,   "t2_rd11"});
        // JTAG read without increment, then wrap
        vq.push_back('{OP_CW, 9'h0FF, 32'hA5A5A5A5,   4'hF, 32'h0,          "t3_cw_ff"});
        vq.push_back('{OP_CW, 9'h000, 32'h0BADF00D,   4'hF, 32'h0,          "t3_cw_00"});
        vq.push_back('{OP_JA, 9'h0FF, 32'h1,          4'hF, 32'h0,          "t3_ja_rd"});
        vq.push_back('{OP_MD, 9'h000, 32'h0,          4'hF, 32'hA5A5A5A5,   "t3_md_ff"});
        vq.push_back('{OP_JN, 9'h000, 32'h0,          4'hF, 32'h0,          "t3_jn0"});
        vq.push_back('{OP_MD, 9'h000, 32'h0,          4'hF, 32'hA5A5A5A5,   "t3_md_stay"});
        vq.push_back('{OP_JN, 9'h000, 32'h0,          4'hF, 32'h0,          "t3_jn1"});
        vq.push_back('{OP_MD, 9'h000, 32'h0,          4'hF, 32'h0BADF00D,   "t3_md_wrap"});
        vq.push_back('{OP_CR, 9'h101, 32'h0,          4'hF, 32'h0BADF00D,   "t3_reg1"});
        // status register, ack, byte enables, unused reg words
        vq.push_back('{OP_CW, 9'h100, 32'h3,          4'hF, 32'h0,          "t5_set"});
        vq.push_back('{OP_ST, 9'h000, 32'h0,          4'hF, 32'h3,          "t5_st_set"});
        vq.push_back('{OP_CR, 9'h100, 32'h0,          4'hF, 32'h3,          "t5_rd_set"});
        vq.push_back('{OP_JA, 9'h020, 32'h2,          4'hF, 32'h0,          "t5_ack"});
        vq.push_back('{OP_ST, 9'h000, 32'h0,          4'hF, 32'h0,          "t5_st_clr"});
        vq.push_back('{OP_CR, 9'h100, 32'h0,          4'hF, 32'h0,          "t5_rd_clr"});
        vq.push_back('{OP_CW, 9'h030, 32'h11223344,   4'hF, 32'h0,          "t5_cw_full"});
        vq.push_back('{OP_CW, 9'h030, 32'hFFFFAAFF,   4'b0010, 32'h0,       "t5_cw_be"});
        vq.push_back('{OP_CR, 9'h030, 32'h0,          4'hF, 32'h1122AA44,   "t5_rd_be"});
        vq.push_back('{OP_CW, 9'h102, 32'h3,          4'hF, 32'h0,          "t5_cw_r2"});
        vq.push_back('{OP_ST, 9'h000, 32'h0,          4'hF, 32'h0,          "t5_st_r2"});
        vq.push_back('{OP_CR, 9'h102, 32'h0,          4'hF, 32'h0,          "t5_rd_r2"});

        foreach (vq[i]) begin
            case (vq[i].op)
                OP_CW: cpu_write(vq[i].addr, vq[i].data, vq[i].be, w);
                OP_CR: begin
                    cpu_read(vq[i].addr, rd, w);
                    check(vq[i].name, rd, vq[i].exp);
                end
                OP_JA: jtag(0, jdo_a(vq[i].addr[7:0], vq[i].data[1], vq[i].data[0]));
                OP_JB: jtag(1, jdo_b(vq[i].data));
                OP_JN: jtag(2, '0);
                OP_MD: check(vq[i].name, mon_d, vq[i].exp);
                OP_ST: check(vq[i].name, {30'b0, mon_error, mon_ready}, vq[i].exp);
                default: ;
            endcase
        end

        // CPU write colliding with a JTAG write
        jtag(0, jdo_a(8'h40, 1'b0, 1'b0));
        @(posedge clk); #1;
        jdo = jdo_b(32'hCAFEF00D);
        take_b = 1'b1;
        avs.avs_address = 9'h041; avs.avs_writedata = 32'h55AA55AA;
        avs.avs_byteenable = 4'hF; avs.avs_write = 1'b1;
        @(negedge clk);
        check("t4_wait_c0", {31'b0, avs.avs_waitrequest}, 32'd1);
        @(posedge clk); #1;
        take_b = 1'b0;
        @(negedge clk);
        check("t4_wait_c1", {31'b0, avs.avs_waitrequest}, 32'd0);
        @(posedge clk); #1;
        avs.avs_write = 1'b0;
        repeat (4) @(posedge clk);
        cpu_read(9'h040, rd, w);
        check("t4_jtag_data", rd, 32'hCAFEF00D);
        cpu_read(9'h041, rd, w);
        check("t4_cpu_data", rd, 32'h55AA55AA);

        // JTAG ack and CPU set in the same cycle
        cpu_write(9'h100, 32'h2, 4'hF, w);
        check("ack_pre", {30'b0, mon_error, mon_ready}, 32'h2);
        @(posedge clk); #1;
        jdo = jdo_a(8'h00, 1'b1, 1'b0);
        take_a = 1'b1;
        avs.avs_address = 9'h100; avs.avs_writedata = 32'h1; avs.avs_write = 1'b1;
        @(negedge clk);
        check("ack_wait", {31'b0, avs.avs_waitrequest}, 32'd0);
        @(posedge clk); #1;
        take_a = 1'b0; avs.avs_write = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("ack_set_wins", {30'b0, mon_error, mon_ready}, 32'h1);

        // reset while a JTAG read is in JRD
        @(posedge clk); #1;
        take_n = 1'b1;
        @(posedge clk); #1;
        take_n = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("t6_busy_jrd", {31'b0, busy}, 32'd1);
        check("t6_wait_rst", {31'b0, avs.avs_waitrequest}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("t6_mondreg", mon_d, 32'h0);
        check("t6_busy", {31'b0, busy}, 32'd0);
        check("t6_status", {30'b0, mon_error, mon_ready}, 32'h0);
        jtag(0, jdo_a(8'h50, 1'b0, 1'b0));
        jtag(1, jdo_b(32'h77777777));
        cpu_read(9'h050, rd, w);
        check("t6_after", rd, 32'h77777777);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
